// File: rtl/done_checker.sv
// Completion aggregator: records sticky done flags from four sub-units and raises done once all
// four have completed. Optional timeout watchdog enabled by defining DONE_TIMEOUT_EN.
module done_checker #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       d,
  output logic       done,
  output logic       done_pulse,
  output logic [3:0] pending,
  output logic       timeout
);

  logic [3:0] seen_q, seen_d;
  logic [3:0] live;
  logic       done_q;

  // Inputs are merged with the record so completion is visible in the same cycle it arrives.
  always_comb begin
    live       = seen_q | {d, c, b, a};
    done       = &live;
    pending    = ~live;
    done_pulse = done & ~done_q;
    seen_d     = clr ? 4'b0000 : live;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seen_q <= 4'b0000;
      done_q <= 1'b0;
    end else begin
      seen_q <= seen_d;
      done_q <= done;
    end
  end

`ifdef DONE_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            timeout_q, timeout_d;

  // Counts only while a round is partially complete; stops once the flag is raised.
  always_comb begin
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    if (clr) begin
      cnt_d     = '0;
      timeout_d = 1'b0;
    end else if (done) begin
      cnt_d = '0;
    end else if ((|seen_q) && !timeout_q) begin
      cnt_d = cnt_q + CntW'(1);
      if (cnt_d == CntMax) begin
        timeout_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_done_checker.sv
// Directed self-checking bench for done_checker: combinational merge, staggered completion,
// clear, asynchronous reset and the timeout watchdog (expectations follow DONE_TIMEOUT_EN).
module tb_done_checker;

`ifdef DONE_TIMEOUT_EN
  localparam bit TimeoutEn = 1'b1;
`else
  localparam bit TimeoutEn = 1'b0;
`endif

  logic       clk, rst, clr, a, b, c, d;
  logic       done, done_pulse, timeout;
  logic [3:0] pending;

  int checks = 0;
  int errors = 0;

  done_checker #(
    .TIMEOUT_CYCLES(8)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .done      (done),
    .done_pulse(done_pulse),
    .pending   (pending),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive inputs just after a falling edge so the next rising edge records them.
  task automatic drive(input logic [3:0] abcd, input logic clr_v);
    @(negedge clk);
    a   = abcd[3];
    b   = abcd[2];
    c   = abcd[1];
    d   = abcd[0];
    clr = clr_v;
    #1;
  endtask

  // Vectors listed as {a,b,c,d}.
  logic [3:0] comb_vec  [8] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001,
                                4'b1001, 4'b0110, 4'b1110, 4'b1111};
  logic       comb_done [8] = '{0, 0, 0, 0, 0, 0, 0, 1};
  logic [3:0] comb_pend [8] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111,
                                4'b0110, 4'b1001, 4'b1000, 4'b0000};

  // Staggered rounds, cycles 1..9, {a,b,c,d} pulses and expected outputs.
  logic [3:0] stg_in    [9] = '{4'b1000, 4'b0000, 4'b0100, 4'b0000, 4'b0010,
                                4'b0000, 4'b0001, 4'b0000, 4'b0000};
  logic       stg_done  [9] = '{0, 0, 0, 0, 0, 0, 1, 1, 1};
  logic       stg_pulse [9] = '{0, 0, 0, 0, 0, 0, 1, 0, 0};
  logic [3:0] stg_pend  [9] = '{4'b1110, 4'b1110, 4'b1100, 4'b1100, 4'b1000,
                                4'b1000, 4'b0000, 4'b0000, 4'b0000};

  initial begin
    rst = 1'b1;
    clr = 1'b0;
    {a, b, c, d} = 4'b0000;
    #12;
    check_eq("reset_done", done, 0);
    check_eq("reset_pulse", done_pulse, 0);
    check_eq("reset_pending", pending, 4'b1111);
    check_eq("reset_timeout", timeout, 0);

    // Held in reset so no edge can record anything: done follows raw inputs.
    for (int i = 0; i < 8; i++) begin
      {a, b, c, d} = comb_vec[i];
      #1;
      check_eq($sformatf("comb_done_%0d", i), done, comb_done[i]);
      check_eq($sformatf("comb_pending_%0d", i), pending, comb_pend[i]);
    end
    {a, b, c, d} = 4'b0000;
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      drive(stg_in[i], 1'b0);
      check_eq($sformatf("stag_done_c%0d", i + 1), done, stg_done[i]);
      check_eq($sformatf("stag_pulse_c%0d", i + 1), done_pulse, stg_pulse[i]);
      check_eq($sformatf("stag_pending_c%0d", i + 1), pending, stg_pend[i]);
    end

    // Clear cycle with a asserted: done holds this cycle, a is discarded.
    drive(4'b1000, 1'b1);
    check_eq("clr_cycle_done", done, 1);
    check_eq("clr_cycle_pulse", done_pulse, 0);
    drive(4'b0000, 1'b0);
    check_eq("after_clr_done", done, 0);
    check_eq("after_clr_pending", pending, 4'b1111);

    // Simultaneous arrival: one strobe, then sticky done.
    drive(4'b1111, 1'b0);
    check_eq("simul_done", done, 1);
    check_eq("simul_pulse", done_pulse, 1);
    drive(4'b0000, 1'b0);
    check_eq("simul_hold_done", done, 1);
    check_eq("simul_hold_pulse", done_pulse, 0);
    drive(4'b0000, 1'b1);
    drive(4'b0000, 1'b0);
    check_eq("simul_cleared", done, 0);

    // Build seen=0111, complete with d, then reset asynchronously before the edge.
    drive(4'b1110, 1'b0);
    drive(4'b0000, 1'b0);
    check_eq("seen0111_pending", pending, 4'b1000);
    check_eq("seen0111_done", done, 0);
    drive(4'b0001, 1'b0);
    check_eq("pre_rst_done", done, 1);
    check_eq("pre_rst_pulse", done_pulse, 1);
    #1 rst = 1'b1;
    #1;
    check_eq("async_rst_done", done, 0);
    check_eq("async_rst_pulse", done_pulse, 0);
    check_eq("async_rst_pending", pending, 4'b0111);
    d = 1'b0;
    #1;
    check_eq("async_rst_pending_idle", pending, 4'b1111);
    @(negedge clk);
    rst = 1'b0;

    // Watchdog: a held alone; flag rises on the 8th edge after seen[0] is recorded.
    drive(4'b1000, 1'b0);
    for (int k = 0; k <= 11; k++) begin
      @(negedge clk);
      #1;
      check_eq($sformatf("timeout_k%0d", k), timeout, TimeoutEn && (k >= 8));
    end
    check_eq("timeout_done_low", done, 0);
    drive(4'b0000, 1'b1);
    check_eq("timeout_in_clr", timeout, TimeoutEn);
    drive(4'b0000, 1'b0);
    check_eq("timeout_after_clr", timeout, 0);
    check_eq("pending_after_clr", pending, 4'b1111);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/done_checker.md
Name: done_checker

Overview:
- Completion aggregator for four parallel sub-units whose completion flags arrive on a, b, c, d.
- Remembers which units have finished since the last clear and raises done once all four have completed, whether simultaneously or at different times.
- Sits between the sub-unit datapaths and the top-level controller FSM, which consumes done / done_pulse and issues clr to start a new round.

Parameters:
- TIMEOUT_CYCLES, 1024, cycles allowed between first completion and full completion before timeout is flagged (used only with DONE_TIMEOUT_EN; must be >= 1).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- clr  input  1  synchronous clear of the completion record; starts a new round.
- a  input  1  completion flag, unit 0.
- b  input  1  completion flag, unit 1.
- c  input  1  completion flag, unit 2.
- d  input  1  completion flag, unit 3.
- done  output  1  all four units complete (combinational + recorded).
- done_pulse  output  1  single-cycle strobe on the rising edge of done.
- pending  output  4  per-unit not-yet-complete mask, bit0=a … bit3=d.
- timeout  output  1  sticky timeout flag (see Optional Feature).

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Internal state: seen[3:0] register, bit0=a … bit3=d. done_q register holds the previous value of done.
- Reset values: seen=0, done_q=0, timeout=0, timeout counter=0.
- Combinational vector: live = seen | {d,c,b,a}.
- done = &live. Zero latency: four inputs high in the same cycle give done=1 with no clock edge needed. With seen=0, done = a&b&c&d exactly.
  - 1000, 0100, 0010, 0001, 1001, 0110, 1110 → done=0.
  - 1111 → done=1.
- pending = ~live, combinational.
- Each rising clk edge:
  - clr=1: seen←0; inputs asserted in that cycle are discarded.
  - clr=0: seen←live. Flags are sticky, so a one-cycle pulse on any input is retained.
- done therefore stays 1 after all four are recorded, even if the inputs drop, until clr or rst.
- done_q←done each edge. done_pulse = done & ~done_q.
  - Exactly one strobe per round.
  - Simultaneous arrival of the last flag and the pulse is fine.
  - In a clr cycle, done and done_pulse still reflect current seen/inputs; the clear takes effect the next cycle.
- Repeated assertion of an already-recorded flag has no effect.
- Inputs are sampled only via seen. No edge detection is applied to a..d.
- rst asserted mid-round: all state clears immediately. done then follows the raw inputs only.
- clr and rst together: rst dominates.

Optional Feature:
- Macro DONE_TIMEOUT_EN.
- Defined:
  - Counter width is clog2(TIMEOUT_CYCLES+1); reset value 0.
  - Counter increments each cycle while (|seen) & ~done & ~timeout.
  - Counter clears on clr, on done=1, and on rst.
  - When the counter reaches TIMEOUT_CYCLES, timeout←1 on that edge.
  - timeout is sticky until clr or rst; done may still assert afterwards.
- Not defined: no counter logic; timeout is tied to 0 and the port is kept.

Test Plan:
- After rst, apply a,b,c,d = 1000, 0100, 0010, 0001, 1001, 0110, 1110, 1111 combinationally, with no clk edges between them → done = 0,0,0,0,0,0,0,1. pending for 1110 = 4'b1000.
- Clocked, staggered completion: pulse a in cycle 1, b in cycle 3, c in cycle 5, d in cycle 7, each for one cycle only → done=0 through cycle 6 and 1 from cycle 7 onward. done_pulse is high only in cycle 7. pending goes 1110→1100→1000→0000.
- With done=1 and inputs low, assert clr for one cycle → done stays 1 during the clr cycle, is 0 next cycle, and pending=1111. Assert a in the clr cycle → a is not recorded.
- Assert rst asynchronously mid-round with seen=0111 → seen, done and done_pulse go to 0 without waiting for a clock edge.
- DONE_TIMEOUT_EN with TIMEOUT_CYCLES=8: assert a only and hold others low → timeout=1 exactly 8 cycles after seen[0] sets, and stays 1. Then clr → timeout=0.
- DONE_TIMEOUT_EN undefined: same stimulus → timeout stays 0 throughout.
